// File: rtl/aes_pkg.sv
// AES building blocks shared by the iterative core and its key-step logic.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  function automatic int unsigned nr(input int unsigned key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Out-of-range indices return 0 so idle-time evaluation stays defined.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i < 4'd10) ? RCON[i] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte index = row + 4*column; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned rw = 0; rw < 4; rw++)
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One on-the-fly key-schedule step: advances the key window and yields rk_r.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 256
) (
  input  logic [KEY_BITS-1:0] window,
  input  logic [3:0]          round,
  output logic [KEY_BITS-1:0] next_window,
  output logic [127:0]        rk
);

  logic [31:0] t, n0, n1, n2, n3;

  if (KEY_BITS == 128) begin : g_k128
    // 4-word window: every round derives a full new round key.
    always_comb begin
      t  = sub_word(rot_word(window[31:0])) ^ {rcon(round - 4'd1), 24'h0};
      n0 = window[127:96] ^ t;
      n1 = window[95:64]  ^ n0;
      n2 = window[63:32]  ^ n1;
      n3 = window[31:0]   ^ n2;
      next_window = {n0, n1, n2, n3};
      rk          = {n0, n1, n2, n3};
    end
  end else begin : g_k256
    // 8-word window: round 1 uses the second key half as-is, later rounds
    // generate four words from the last word and shift the window left.
    always_comb begin
      if (!round[0]) t = sub_word(rot_word(window[31:0])) ^ {rcon({1'b0, round[3:1]} - 4'd1), 24'h0};
      else           t = sub_word(window[31:0]);
      n0 = window[255:224] ^ t;
      n1 = window[223:192] ^ n0;
      n2 = window[191:160] ^ n1;
      n3 = window[159:128] ^ n2;
      if (round == 4'd1) begin
        next_window = window;
        rk          = window[127:0];
      end else begin
        next_window = {window[127:0], n0, n1, n2, n3};
        rk          = {n0, n1, n2, n3};
      end
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: one round per clock, handshaked in/out, held output.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  localparam logic [3:0] NR = 4'(nr(KEY_BITS));

  state_t              state, state_n;
  logic [3:0]          round, round_n;
  logic [127:0]        state_reg, state_reg_n;
  logic [KEY_BITS-1:0] key_win, key_win_n, key_next;
  logic                out_valid_n;
  logic [127:0]        out_data_n;
  logic [127:0]        rk, sr_out, round_res;
  logic                out_free;

  aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .window      (key_win),
    .round       (round),
    .next_window (key_next),
    .rk          (rk)
  );

  assign sr_out    = shift_rows(sub_bytes(state_reg));
  assign round_res = (round == NR) ? (sr_out ^ rk) : (mix_columns(sr_out) ^ rk);
  assign out_free  = !out_valid || out_ready;
  // Held low throughout reset even though the state register already reads IDLE.
  assign in_ready  = (state == IDLE) && rst_n;

  // Register all FSM, datapath and output-holding state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round     <= '0;
      state_reg <= '0;
      key_win   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      round     <= round_n;
      state_reg <= state_reg_n;
      key_win   <= key_win_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

  // Next-state, round datapath and output register control; clear wins over all.
  always_comb begin
    state_n     = state;
    round_n     = round;
    state_reg_n = state_reg;
    key_win_n   = key_win;
    out_valid_n = out_valid && !out_ready;
    out_data_n  = out_data;
    if (clear) begin
      state_n     = IDLE;
      round_n     = '0;
      key_win_n   = '0;
      out_valid_n = 1'b0;
      out_data_n  = '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          state_reg_n = in_data ^ in_key[KEY_BITS-1 -: 128];
          key_win_n   = in_key;
          round_n     = 4'd1;
          state_n     = RUN;
        end
        RUN: begin
          key_win_n = key_next;
          if (round == NR) begin
            round_n = '0;
            if (out_free) begin
              out_data_n  = round_res;
              out_valid_n = 1'b1;
              state_n     = IDLE;
            end else begin
              state_reg_n = round_res;
              state_n     = DONE;
            end
          end else begin
            state_reg_n = round_res;
            round_n     = round + 4'd1;
          end
        end
        DONE: if (out_free) begin
          out_data_n  = state_reg;
          out_valid_n = 1'b1;
          state_n     = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed FIPS-197 / SP800-38A vector bench for both key sizes.
module tb_aes_iter_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  logic         iv_a = 1'b0, rdy_a, ov_a, or_a = 1'b1;
  logic [127:0] din_a = '0, key_a = '0, dout_a;
  logic         iv_b = 1'b0, rdy_b, ov_b, or_b = 1'b1;
  logic [127:0] din_b = '0, dout_b;
  logic [255:0] key_b = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  aes_iter_core #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv_a), .in_ready(rdy_a), .in_data(din_a), .in_key(key_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(dout_a)
  );

  aes_iter_core #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv_b), .in_ready(rdy_b), .in_data(din_b), .in_key(key_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(dout_b)
  );

  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic [127:0] bk [8] = '{K_B, K_B, K_B, K_B, K_B, K_C1, 128'h0, K_B};
  logic [127:0] bp [8] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                           128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710,
                           P_B, P_C, 128'h0, 128'h6bc1bee22e409f96e93d7e117393172a};
  logic [127:0] bc [8] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                           128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4,
                           C_B, C_C1, C_Z, 128'h3ad77bb40d7a3660a89ecaf32466ef97};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_a(input logic [127:0] k, input logic [127:0] p, output int unsigned acc);
    int unsigned w = 0;
    key_a = k; din_a = p; iv_a = 1'b1;
    while (!rdy_a && w < 60) begin @(negedge clk); w++; end
    chk("accept_ready_a", rdy_a, 1);
    acc = cycle;
    @(negedge clk);
    iv_a = 1'b0;
  endtask

  task automatic send_b(input logic [255:0] k, input logic [127:0] p, output int unsigned acc);
    int unsigned w = 0;
    key_b = k; din_b = p; iv_b = 1'b1;
    while (!rdy_b && w < 60) begin @(negedge clk); w++; end
    chk("accept_ready_b", rdy_b, 1);
    acc = cycle;
    @(negedge clk);
    iv_b = 1'b0;
  endtask

  task automatic expect_a(input string tag, input int unsigned lat, input logic [127:0] ct);
    int unsigned k = 0;
    while (!ov_a && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_ct"}, dout_a, ct);
  endtask

  task automatic expect_b(input string tag, input int unsigned lat, input logic [127:0] ct);
    int unsigned k = 0;
    while (!ov_b && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_ct"}, dout_b, ct);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, prev;
    // Reset state
    #1;
    chk("rst_in_ready", rdy_a, 0);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_data", dout_a, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", rdy_a, 1);

    // FIPS-197 known answers
    send_a(K_B, P_B, acc);       expect_a("fips_b", 10, C_B);
    send_b({K_C1, 128'h101112131415161718191a1b1c1d1e1f}, P_C, acc);
    expect_b("fips_c3", 14, 128'h8ea2b7ca516745bfeafc49904b496089);

    // Back-to-back, AES-128
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      send_a(bk[i], bp[i], acc);
      if (i > 0) chk("b2b_interval_128", acc - prev, 11);
      prev = acc;
      expect_a("b2b128", 10, bc[i]);
    end

    // Back-to-back, AES-256
    send_b(256'h0, 128'h0, prev);
    expect_b("z256", 14, 128'hdc95c078a2408989ad48a21492842087);
    send_b(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
           128'h6bc1bee22e409f96e93d7e117393172a, acc);
    chk("b2b_interval_256", acc - prev, 15);
    expect_b("ecb256", 14, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8);

    // Backpressure across two blocks
    @(negedge clk);
    or_a = 1'b0;
    send_a(K_B, P_B, acc);  expect_a("bp_first", 10, C_B);
    send_a(K_C1, P_C, acc);
    cyc(10);
    chk("bp_done_valid", ov_a, 1);
    chk("bp_done_data", dout_a, C_B);
    chk("bp_done_in_ready", rdy_a, 0);
    cyc(2);
    chk("bp_hold_data", dout_a, C_B);
    chk("bp_hold_in_ready", rdy_a, 0);
    or_a = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", ov_a, 1);
    chk("bp_second_data", dout_a, C_C1);
    @(negedge clk);
    chk("bp_drained_valid", ov_a, 0);
    chk("bp_drained_in_ready", rdy_a, 1);

    // clear at round 5
    send_a(K_B, P_B, acc);
    cyc(4);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_out_valid", ov_a, 0);
    chk("clr_in_ready", rdy_a, 1);
    cyc(12);
    chk("clr_no_output", ov_a, 0);
    send_a(128'h0, 128'h0, acc);  expect_a("clr_next", 10, C_Z);

    // clear on the acceptance edge
    @(negedge clk);
    key_a = K_B; din_a = P_B; iv_a = 1'b1; clear = 1'b1;
    @(negedge clk);
    iv_a = 1'b0; clear = 1'b0;
    chk("clr_acc_in_ready", rdy_a, 1);
    cyc(12);
    chk("clr_acc_no_output", ov_a, 0);

    // Async reset while in DONE
    or_a = 1'b0;
    send_a(K_B, P_B, acc);  expect_a("rst_done_first", 10, C_B);
    send_a(K_C1, P_C, acc);
    cyc(11);
    chk("rst_done_in_ready", rdy_a, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_out_valid", ov_a, 0);
    chk("rst_done_out_data", dout_a, 0);
    @(negedge clk); rst_n = 1'b1; or_a = 1'b1;

    // Async reset mid-round
    send_a(K_B, P_B, acc);
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", ov_a, 0);
    chk("rst_mid_in_ready", rdy_a, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc(12);
    chk("rst_mid_no_output", ov_a, 0);
    send_a(K_C1, P_C, acc);  expect_a("post_rst_c1", 10, C_C1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Parametrised iterative AES encryption core: one full AES round per clock, AES-128 or AES-256 selected at elaboration, key expanded on the fly. It replaces the fixed AES-256, four-cycles-per-round encrypt unit. It adds valid/ready handshakes on both sides, an output holding register with backpressure, and a synchronous abort. It sits between the host block-buffer and the crypto output FIFO.

## Interface
- KEY_BITS, 256, key length; legal values 128 or 256; any other value is an elaboration error. NR = 10 for 128, 14 for 256.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort; drops the in-flight block and the output register.
- in_valid  in  1  in_data/in_key valid.
- in_ready  out  1  core can accept a block. Reset value 0 while rst_n is low, 1 after.
- in_data  in  128  plaintext; [127:120] = FIPS-197 byte 0, column-major.
- in_key  in  KEY_BITS  cipher key; [KEY_BITS-1:KEY_BITS-8] = key byte 0.
- out_valid  out  1  out_data holds a ciphertext. Reset value 0.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  ciphertext, same byte order. Reset value 0.

## Operation
- States: IDLE, RUN, DONE. Reset and clear both force IDLE, round=0, out_valid=0, out_data=0, and zero the key window.
- IDLE: in_ready=1. On in_valid:
  - state_reg <= in_data ^ rk0, where rk0 = top 128 bits of the key.
  - key window <= in_key.
  - round <= 1.
  - Go to RUN.
  - in_data and in_key are sampled only on this edge.
- RUN, round r in 1..NR-1: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_r.
- RUN, round NR: MixColumns is omitted, giving result = ShiftRows(SubBytes(state_reg)) ^ rk_NR.
  - If out_valid=0 or out_ready=1: out_data <= result, out_valid <= 1, go to IDLE.
  - Otherwise: state_reg <= result, go to DONE.
- DONE: when out_valid=0 or out_ready=1, out_data <= state_reg, out_valid <= 1, go to IDLE.
- Output register:
  - out_valid clears on out_valid & out_ready unless the register is reloaded on the same edge.
  - out_data is stable while out_valid=1 and out_ready=0.
- Key schedule, AES-128: window is 4 words. Each round, next = step(window, RotWord+SubWord+Rcon[r]), and rk_r = next.
- Key schedule, AES-256: window is 8 words.
  - rk1 = window low 128 bits.
  - For r≥2, 4 new words are generated from the last word, then the window shifts left 128 bits and rk_r = the new words.
  - r even: RotWord+SubWord+Rcon[r/2].
  - r odd: SubWord only.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- clear has priority over every transition; rst_n has priority over clear.
- in_valid while in_ready=0 is ignored; it is not queued.

## Timing
- Latency: acceptance edge E0, round r completes at edge Er. out_valid rises after E_NR: 10 cycles for 128, 14 for 256.
- Throughput: one block per NR+1 cycles with out_ready held high. in_ready is low from the cycle after E0 through the cycle of E_NR.
- Backpressure: each extra cycle that out_ready stays low at completion adds one cycle in DONE.
- Simultaneous events:
  - out_valid & out_ready on the same edge a new result is written: the new result lands, and out_valid stays 1.
  - clear on the acceptance edge: the block is dropped.
- Reset mid-round: all state is lost, no partial output is emitted, and the first post-reset accept is clean.

## Structure
- aes_pkg holds:
  - sbox function, xtime, Rcon constant array.
  - nr(KEY_BITS) function.
  - state enum {IDLE, RUN, DONE}.
  - Combinational round functions: sub_bytes, shift_rows, mix_columns.
- One sub-module, aes_key_step: combinational. Inputs are the window, round, and KEY_BITS. Outputs are the next window and rk_r.
- The core holds the FSM, round counter, state_reg, key window, and output register.

## Test plan
- AES-128 (FIPS-197 App. B): key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
- AES-256 (C.3): key 000102…1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, latency 14.
- Backpressure: hold out_ready=0 across two consecutive blocks -> first result stable, second held in DONE with in_ready=0; release out_ready -> both results delivered in order.
- Back-to-back with out_ready=1: 8 random blocks checked against a reference model -> one accept every NR+1 cycles, all ciphertexts match.
- clear at round 5 -> out_valid stays 0, in_ready=1 next cycle; next block encrypts correctly.
- Async reset asserted mid-round and in DONE -> out_valid=0 and out_data=0 immediately; the C.1 AES-128 vector (pt 00112233…ff, key 00…0f -> 69c4e0d86a7b0430d8cdb78070b4c55a) passes after release.
